// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo up/down counter: saturation mode
// constants and the elaboration-time parameter legality check.
package mod_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // True when the (WIDTH, MODULUS, SATURATE) triple describes a buildable
    // counter. The modulus is 64-bit so that 2**32 is representable.
    function automatic bit params_legal(input int width,
                                        input longint unsigned modulus,
                                        input int saturate);
        bit ok;
        ok = 1'b1;
        if (width < WIDTH_MIN || width > WIDTH_MAX)
            ok = 1'b0;
        else if (modulus < 64'd2 || modulus > (64'd1 << width))
            ok = 1'b0;
        if (saturate != MODE_WRAP && saturate != MODE_SAT)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-count calculation. Given the current count and the
// direction, produces the value one enabled step would register and flags
// when that step is attempted at the bound in the current direction.
module mod_counter_step
    import mod_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] count_next,
    output logic             hit
);

    // MODULUS-1 always fits in WIDTH bits, so the bound compare never needs
    // an intermediate value wider than the register.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               HOLD    = (SATURATE == MODE_SAT);

    logic at_bound;

    // Bound detection depends on direction only; up and down limits differ.
    always_comb begin
        at_bound = 1'b0;
        if (up)
            at_bound = (count == MAX_VAL);
        else
            at_bound = (count == '0);
    end

    // Step: wrap to the opposite bound or hold, otherwise +/-1.
    always_comb begin
        count_next = count;
        hit        = at_bound;
        if (at_bound) begin
            if (HOLD)
                count_next = count;
            else if (up)
                count_next = '0;
            else
                count_next = MAX_VAL;
        end else if (up) begin
            count_next = count + ONE;
        end else begin
            count_next = count - ONE;
        end
    end

endmodule

// File: rtl/mod_up_down_counter.sv
// Modulo up/down counter with synchronous clear and clamped load, a
// one-cycle terminal-count pulse and a sticky overflow/underflow flag.
// Edge priority is clear, then load, then enabled step, else hold.
module mod_up_down_counter
    import mod_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    if (!params_legal(WIDTH, MODULUS, SATURATE)) begin : g_bad_params
        $error("mod_up_down_counter: illegal WIDTH/MODULUS/SATURATE combination");
    end

    logic [WIDTH-1:0] step_next;
    logic             step_hit;
    logic [WIDTH-1:0] load_clamped;

    mod_counter_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .count      (count),
        .up         (up),
        .count_next (step_next),
        .hit        (step_hit)
    );

    // Out-of-range load values clamp to the top of the range so no value
    // at or above MODULUS can ever be registered.
    always_comb begin
        load_clamped = MAX_VAL;
        if (64'(load_val) < MODULUS)
            load_clamped = load_val;
    end

    // Count register and flags; tc is a single-cycle pulse, ovf is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (en) begin
            count <= step_next;
            tc    <= step_hit;
            if (step_hit)
                ovf <= 1'b1;
        end else begin
            tc    <= 1'b0;
        end
    end

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Bench for mod_up_down_counter: three configurations driven by shared
// inputs, a per-instance arithmetic model, directed sequences with literal
// expectations, and a randomized phase with occasional asynchronous resets.
module tb_mod_up_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [3:0] cnt_w, cnt_s;
    logic [2:0] cnt_8;
    logic       tc_w, ovf_w, amax_w, amin_w;
    logic       tc_s, ovf_s, amax_s, amin_s;
    logic       tc_8, ovf_8, amax_8, amin_8;

    int  checks = 0;
    int  errors = 0;
    bit  checking = 1'b0;

    int  mods[3] = '{10, 10, 8};
    bit  sats[3] = '{1'b0, 1'b1, 1'b0};
    int  m_cnt[3];
    bit  m_tc[3];
    bit  m_ovf[3];

    mod_up_down_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_w), .tc(tc_w), .ovf(ovf_w),
        .at_max(amax_w), .at_min(amin_w));

    mod_up_down_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_s), .tc(tc_s), .ovf(ovf_s),
        .at_max(amax_s), .at_min(amin_s));

    mod_up_down_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[2:0]), .count(cnt_8), .tc(tc_8), .ovf(ovf_8),
        .at_max(amax_8), .at_min(amin_8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for instance i from the counting rules directly.
    function automatic void model_step(input int i);
        int mx;
        int lvv;
        mx  = mods[i] - 1;
        lvv = (i == 2) ? int'(lv[2:0]) : int'(lv);
        if (clr) begin
            m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end else if (load) begin
            m_cnt[i] = (lvv < mods[i]) ? lvv : mx;
            m_tc[i]  = 1'b0;
        end else if (en) begin
            if ((up && m_cnt[i] == mx) || (!up && m_cnt[i] == 0)) begin
                m_tc[i]  = 1'b1;
                m_ovf[i] = 1'b1;
                if (!sats[i]) m_cnt[i] = up ? 0 : mx;
            end else begin
                m_tc[i]  = 1'b0;
                m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            end
        end else begin
            m_tc[i] = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                model_step(i);
            end
        end
    end

    task automatic cmp(input int i, input int c, input bit t, input bit o,
                       input bit amx, input bit amn);
        chk($sformatf("count[%0d]", i), c, m_cnt[i]);
        chk($sformatf("tc[%0d]", i), t, m_tc[i]);
        chk($sformatf("ovf[%0d]", i), o, m_ovf[i]);
        chk($sformatf("at_max[%0d]", i), amx, m_cnt[i] == mods[i] - 1);
        chk($sformatf("at_min[%0d]", i), amn, m_cnt[i] == 0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp(0, int'(cnt_w), tc_w, ovf_w, amax_w, amin_w);
            cmp(1, int'(cnt_s), tc_s, ovf_s, amax_s, amin_s);
            cmp(2, int'(cnt_8), tc_8, ovf_8, amax_8, amin_8);
        end
    end

    // One clock: inputs change on the falling edge, results read 1 after the rise.
    task automatic drive(input bit e, input bit u, input bit c, input bit l,
                         input logic [3:0] v);
        @(negedge clk);
        en = e; up = u; clr = c; load = l; lv = v;
        @(posedge clk);
        #1;
    endtask

    int e33[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int e34[5]  = '{9, 8, 7, 6, 5};
    int e38[4]  = '{7, 0, 7, 0};
    int pulses;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checking = 1'b1;
        #1;
        chk("reset_count", cnt_w, 0);
        chk("reset_tc", tc_w, 0);
        chk("reset_ovf", ovf_w, 0);
        chk("reset_at_min", amin_w, 1);
        chk("reset_at_max", amax_w, 0);

        // Count up through the wrap.
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 0, 0, 4'd0);
            chk($sformatf("up_seq_count%0d", k), cnt_w, e33[k]);
            chk($sformatf("up_seq_tc%0d", k), tc_w, (k == 9) ? 1 : 0);
        end
        chk("up_seq_ovf", ovf_w, 1);

        // Count down from 0, then clear.
        drive(0, 0, 1, 0, 4'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 4'd0);
            chk($sformatf("down_seq_count%0d", k), cnt_w, e34[k]);
            if (tc_w) pulses++;
        end
        chk("down_seq_tc_pulses", pulses, 1);
        chk("down_seq_ovf", ovf_w, 1);
        drive(0, 0, 1, 0, 4'd0);
        chk("clr_count", cnt_w, 0);
        chk("clr_ovf", ovf_w, 0);
        chk("clr_tc", tc_w, 0);

        // Saturating instance: load 8 (wins over en), then held attempts.
        drive(1, 1, 0, 1, 4'd8);
        chk("sat_load_count", cnt_s, 8);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 4'd0);
            chk($sformatf("sat_count%0d", k), cnt_s, 9);
            if (tc_s) pulses++;
        end
        chk("sat_tc_pulses", pulses, 2);
        chk("sat_ovf", ovf_s, 1);

        // Out-of-range load clamps; clr beats load.
        drive(0, 0, 0, 1, 4'd13);
        chk("load_clamp_count", cnt_w, 9);
        chk("load_clamp_ovf_kept", ovf_w, 1);
        drive(0, 0, 1, 1, 4'd5);
        chk("load_clr_count", cnt_w, 0);

        // Asynchronous reset mid-count.
        for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, 4'd0);
        chk("pre_reset_count", cnt_w, 6);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_reset_count", cnt_w, 0);
        chk("async_reset_ovf", ovf_w, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 0, 0, 4'd0);
        chk("post_reset_step", cnt_w, 1);

        // WIDTH=3 natural-wrap instance: alternate down/up from 0.
        drive(0, 0, 1, 0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1, (k % 2 == 1), 0, 0, 4'd0);
            chk($sformatf("alt_count%0d", k), cnt_8, e38[k]);
            chk($sformatf("alt_tc%0d", k), tc_8, 1);
            chk($sformatf("alt_at_max%0d", k), amax_8, (e38[k] == 7) ? 1 : 0);
            chk($sformatf("alt_at_min%0d", k), amin_8, (e38[k] == 0) ? 1 : 0);
        end

        // Randomized phase against the model.
        for (int n = 0; n < 800; n++) begin
            int r;
            @(negedge clk);
            r    = int'($urandom_range(0, 199));
            clr  = (r < 4);
            load = (r >= 4 && r < 14);
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 1) == 1);
            lv   = 4'($urandom_range(0, 15));
            if (r == 199) begin
                #2 rst = 1'b0;
                #1;
                chk("rand_async_reset_w", cnt_w, 0);
                chk("rand_async_reset_8", cnt_8, 0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
